// File: rtl/exp2_cordic_if.sv
// Handshake and angle-table bus for the exp2 CORDIC sequencer.
// The slave side is the sequencer. The master side is the operand source, the table and the result sink.
interface exp2_cordic_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_z;
   logic [4:0]  count;
   logic [31:0] partial;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic        out_ovf;
   logic        busy;

   modport master (
      output in_valid, in_z, partial, out_ready,
      input  in_ready, count, out_valid, out_data, out_ovf, busy
   );

   modport slave (
      input  in_valid, in_z, partial, out_ready,
      output in_ready, count, out_valid, out_data, out_ovf, busy
   );
endinterface

// File: rtl/exp2_cordic_ctrl.sv
// Hyperbolic-CORDIC sequencer that computes 2^z for a signed Q8.24 operand.
// The integer part of z becomes a final shift. The fractional part is rotated through the external angle table.
module exp2_cordic_ctrl #(
   parameter int          N_ITER = 24,
   parameter logic [31:0] X0     = 32'h0135_1E88
) (
   input  logic         clk,
   input  logic         rst_n,
   exp2_cordic_if.slave bus
);
   localparam logic [4:0] LAST = 5'(N_ITER);

   typedef enum logic [1:0] {S_IDLE, S_ITER, S_NORM, S_DONE} state_t;

   state_t             st, nxt;
   logic signed [31:0] x, y, z;
   logic signed [7:0]  n;
   logic [4:0]         idx;
   logic               rep;
   logic [31:0]        out_data_q;
   logic               out_ovf_q;

   logic               d_pos, rep_now, last;
   logic signed [31:0] xs, ys, p;
   logic signed [31:0] x_nxt, y_nxt, z_nxt;
   logic [31:0]        m, res;
   logic [7:0]         neg_n;
   logic               ovf;

   // Micro-rotation. The direction follows the sign of the residual angle.
   always_comb begin
      d_pos = ~z[31];
      xs    = x >>> idx;
      ys    = y >>> idx;
      p     = $signed(bus.partial);
      x_nxt = d_pos ? x + ys : x - ys;
      y_nxt = d_pos ? y + xs : y - xs;
      z_nxt = d_pos ? z - p  : z + p;
   end

   // Indices 4 and 13 run twice. This keeps the hyperbolic iteration convergent.
   assign rep_now = ((idx == 5'd4) || (idx == 5'd13)) && !rep;
   assign last    = (idx == LAST) && !rep_now;

   // Normalisation. The CORDIC result m is in [1,2) and is scaled by 2^n.
   always_comb begin
      m     = 32'(x + y);
      neg_n = 8'(-n);
      res   = '0;
      ovf   = 1'b0;
      if (n >= 8'sd7) begin
         res = 32'h7FFF_FFFF;
         ovf = 1'b1;
      end else if (n >= 8'sd0) begin
         res = m << n[2:0];
      end else if (n >= -8'sd31) begin
         res = m >> neg_n[4:0];
      end
   end

   always_comb begin
      nxt = st;
      case (st)
         S_IDLE:  if (bus.in_valid)  nxt = S_ITER;
         S_ITER:  if (last)          nxt = S_NORM;
         S_NORM:                     nxt = S_DONE;
         S_DONE:  if (bus.out_ready) nxt = S_IDLE;
         default:                    nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) st <= S_IDLE;
      else        st <= nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x          <= '0;
         y          <= '0;
         z          <= '0;
         n          <= '0;
         idx        <= '0;
         rep        <= 1'b0;
         out_data_q <= '0;
         out_ovf_q  <= 1'b0;
      end else begin
         case (st)
            S_IDLE: if (bus.in_valid) begin
               n   <= $signed(bus.in_z[31:24]);
               z   <= $signed({8'h00, bus.in_z[23:0]});
               x   <= $signed(X0);
               y   <= '0;
               idx <= 5'd1;
               rep <= 1'b0;
            end
            S_ITER: begin
               x <= x_nxt;
               y <= y_nxt;
               z <= z_nxt;
               if (rep_now) begin
                  rep <= 1'b1;
               end else begin
                  rep <= 1'b0;
                  if (!last) idx <= idx + 5'd1;
               end
            end
            S_NORM: begin
               out_data_q <= res;
               out_ovf_q  <= ovf;
            end
            default: ;
         endcase
      end
   end

   assign bus.in_ready  = (st == S_IDLE);
   assign bus.busy      = (st != S_IDLE);
   assign bus.count     = (st == S_ITER) ? idx : 5'd0;
   assign bus.out_valid = (st == S_DONE);
   assign bus.out_data  = out_data_q;
   assign bus.out_ovf   = out_ovf_q;
endmodule

// File: tb/tb_exp2_cordic_ctrl.sv
// Directed bench for exp2_cordic_ctrl.
// The reference is a real-arithmetic 2^z model, and the count sequence is rebuilt from the repeat rule.
module tb_exp2_cordic_ctrl;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   exp2_cordic_if bus ();
   exp2_cordic_if b16 ();

   exp2_cordic_ctrl u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   exp2_cordic_ctrl #(.N_ITER(16)) u_dut16 (.clk(clk), .rst_n(rst_n), .bus(b16));

   int checks = 0;
   int errors = 0;
   logic [31:0] tbl [0:31];

   assign bus.partial = tbl[bus.count];
   assign b16.partial = tbl[b16.count];

   task automatic chk(input string name, input logic ok, input longint act, input longint exp);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Reference: 2^z from real arithmetic, with saturation and underflow rules and the error budget
   function automatic void model(input logic [31:0] zin, output logic [31:0] e, output logic ov,
                                 output longint tol);
      real r;
      int  fl;
      r  = $itor($signed(zin)) / 16777216.0;
      fl = $rtoi($floor(r));
      ov = 1'b0;
      tol = (fl > 0) ? (longint'(16) << fl) : 16;
      if (r >= 7.0) begin
         e = 32'h7FFF_FFFF; ov = 1'b1; tol = 0;
      end else if (r < -31.0) begin
         e = 32'h0; tol = 0;
      end else begin
         e = 32'(longint'($pow(2.0, r) * 16777216.0));
      end
   endfunction

   function automatic longint absdiff(input logic [31:0] a, input logic [31:0] b);
      longint dd;
      dd = longint'(a) - longint'(b);
      return (dd < 0) ? -dd : dd;
   endfunction

   // Tracks the operand in flight
   logic        pend;
   logic [31:0] mz;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) pend <= 1'b0;
      else if (bus.in_valid && bus.in_ready) begin
         pend <= 1'b1;
         mz   <= bus.in_z;
      end else if (bus.out_valid && bus.out_ready) pend <= 1'b0;
   end

   always @(negedge clk) begin
      logic [31:0] e;
      logic        ov;
      longint      tol;
      if (rst_n && bus.out_valid) begin
         model(mz, e, ov, tol);
         chk("out_without_op", pend, 1, 0);
         chk("out_data_model", absdiff(bus.out_data, e) <= tol, bus.out_data, e);
         chk("out_ovf_model", bus.out_ovf == ov, bus.out_ovf, ov);
      end
   end

   task automatic build_seq(input int last, output int s[$]);
      s = {};
      for (int i = 1; i <= last; i++) begin
         s.push_back(i);
         if (i == 4 || i == 13) s.push_back(i);
      end
      s.push_back(0);
      s.push_back(0);
   endtask

   task automatic run_op(input logic [31:0] zin, input int hold, input string tag,
                         output logic [31:0] d, output logic o);
      int q[$];
      int ex[$];
      int lat;
      logic ok;
      @(negedge clk);
      chk({tag, "_idle"}, bus.count == 0 && bus.in_ready == 1'b1, {bus.count, bus.in_ready}, 1);
      bus.out_ready = (hold == 0);
      bus.in_valid  = 1'b1;
      bus.in_z      = zin;
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      q.push_back(int'(bus.count));
      lat = 0;
      while (!bus.out_valid && lat < 200) begin
         @(posedge clk); #1;
         lat++;
         q.push_back(int'(bus.count));
      end
      chk({tag, "_latency"}, lat == 27, lat, 27);
      build_seq(24, ex);
      ok = (q.size() == ex.size());
      for (int i = 0; i < q.size() && i < ex.size(); i++) if (q[i] != ex[i]) ok = 1'b0;
      chk({tag, "_count_seq"}, ok, q.size(), ex.size());
      d = bus.out_data;
      o = bus.out_ovf;
      for (int c = 0; c < hold; c++) begin
         bus.in_valid = c[0];
         bus.in_z     = 32'h0100_0000;
         @(posedge clk); #1;
         chk({tag, "_hold"}, bus.out_valid && !bus.in_ready && bus.out_data == d && bus.out_ovf == o,
             bus.out_data, d);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      chk({tag, "_release"}, !bus.out_valid && bus.in_ready, {bus.out_valid, bus.in_ready}, 1);
   endtask

   initial begin
      logic [31:0] d, e;
      logic        o;
      longint      tol;
      int          q16[$];
      int          ex16[$];
      int          lat;
      logic        ok;
      real         t;

      rst_n = 1'b1;
      bus.in_valid = 1'b0; bus.in_z = '0; bus.out_ready = 1'b1;
      b16.in_valid = 1'b0; b16.in_z = '0; b16.out_ready = 1'b1;
      for (int i = 0; i < 32; i++) tbl[i] = '0;
      for (int i = 1; i <= 24; i++) begin
         t = $pow(2.0, -i);
         tbl[i] = 32'(longint'(0.5 * $ln((1.0 + t) / (1.0 - t)) / $ln(2.0) * 16777216.0));
      end
      #1 rst_n = 1'b0;
      #2;
      chk("rst_outputs", !bus.out_valid && bus.count == 0 && !bus.busy && bus.in_ready,
          {bus.out_valid, bus.count, bus.busy}, 0);
      chk("rst_data", bus.out_data == 0 && !bus.out_ovf, bus.out_data, 0);
      repeat (3) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;

      model(32'h0000_0000, e, o, tol);
      chk("model_z0", e == 32'h0100_0000 && !o, e, 32'h0100_0000);
      model(32'h0180_0000, e, o, tol);
      chk("model_z1p5", absdiff(e, 32'h02D4_13CD) <= 1, e, 32'h02D4_13CD);
      model(32'hFF00_0000, e, o, tol);
      chk("model_zm1", e == 32'h0080_0000, e, 32'h0080_0000);
      model(32'h0700_0000, e, o, tol);
      chk("model_sat", e == 32'h7FFF_FFFF && o, e, 32'h7FFF_FFFF);

      run_op(32'h0000_0000, 0, "z0", d, o);
      chk("z0_lit", absdiff(d, 32'h0100_0000) <= 8 && !o, d, 32'h0100_0000);
      run_op(32'h0180_0000, 0, "z1p5", d, o);
      chk("z1p5_lit", absdiff(d, 32'h02D4_13CD) <= 32 && !o, d, 32'h02D4_13CD);
      run_op(32'hFF00_0000, 0, "zm1", d, o);
      chk("zm1_lit", absdiff(d, 32'h0080_0000) <= 8 && !o, d, 32'h0080_0000);
      run_op(32'h0700_0000, 0, "z7", d, o);
      chk("z7_lit", d == 32'h7FFF_FFFF && o, d, 32'h7FFF_FFFF);
      run_op(32'hE000_0000, 0, "zm32", d, o);
      chk("zm32_lit", d == 32'h0 && !o, d, 0);
      run_op(32'h0280_0000, 10, "hold", d, o);
      run_op(32'hFFC0_0000, 0, "zm0p25", d, o);
      run_op(32'h06FF_FFFF, 0, "zmax", d, o);
      run_op(32'hE100_0000, 0, "zm31", d, o);
      run_op(32'h0080_0000, 0, "z0p5", d, o);

      // Asynchronous reset during the 10th iteration cycle
      @(negedge clk);
      bus.in_valid = 1'b1; bus.in_z = 32'h0040_0000;
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      repeat (9) @(posedge clk);
      #2 chk("pre_rst_busy", bus.busy && bus.count != 0, bus.busy, 1);
      rst_n = 1'b0;
      #1 chk("mid_rst", !bus.out_valid && bus.count == 0 && !bus.busy && bus.in_ready,
             {bus.out_valid, bus.count, bus.busy}, 0);
      @(negedge clk) rst_n = 1'b1;
      run_op(32'h0040_0000, 0, "post_rst", d, o);

      // Reduced-iteration build
      @(negedge clk);
      b16.in_valid = 1'b1; b16.in_z = 32'h0000_0000;
      @(posedge clk);
      #1 b16.in_valid = 1'b0;
      q16.push_back(int'(b16.count));
      lat = 0;
      while (!b16.out_valid && lat < 200) begin
         @(posedge clk); #1;
         lat++;
         q16.push_back(int'(b16.count));
      end
      chk("n16_latency", lat == 19, lat, 19);
      build_seq(16, ex16);
      ok = (q16.size() == ex16.size());
      for (int i = 0; i < q16.size() && i < ex16.size(); i++) if (q16[i] != ex16[i]) ok = 1'b0;
      chk("n16_count_seq", ok, q16.size(), ex16.size());
      chk("n16_data", absdiff(b16.out_data, 32'h0100_0000) <= 1024, b16.out_data, 32'h0100_0000);
      @(posedge clk); #1;
      chk("n16_release", !b16.out_valid && b16.in_ready, b16.out_valid, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
